reg_bank: RTL and testbench
===========================

# reg_bank

General-purpose register file of the multicycle MIPS datapath. Sits directly downstream of the destination-register mux and consumes its 5-bit write index, along with the write-data mux output and the register-write control flag. It provides two combinational read ports, rs and rt, that feed registers A/B. It also provides a synchronous write port, plus the reset initialisation of $sp and $zero.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, index width (32 registers)
- SP_INIT, 32'd227, value loaded into $29 ($sp) at reset
- RA_IDX, 31, link register index; written by jal through the mux
- SP_IDX, 29, stack pointer index

Ports (one clock; reset is synchronous and active-low):
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low; sampled on the rising edge of clk
- flagRegWrite  input  1  write enable from the control FSM
- w_readReg1  input  5  rs read index (instr[25:21])
- w_readReg2  input  5  rt read index (instr[20:16])
- w_writeReg  input  5  write index, i.e. the destination-mux output
- w_writeData  input  32  write data from the memtoReg mux
- w_readData1  output  32  rs contents
- w_readData2  output  32  rt contents
- w_spOut  output  32  current $29, for debug or waveform observation

## Operation
- Storage: 32 x DATA_W flops. Index 0 is never written and always reads 0.
- Reset: when reset=0 at a rising edge, all registers clear to 0, except $29 which is set to SP_INIT.
  - Reset has priority over any write in the same cycle.
  - Every output shows 0 during reset, except w_spOut, which shows SP_INIT once the reset edge has occurred.
- Write: when reset=1 and flagRegWrite=1 at a rising edge, reg[w_writeReg] <= w_writeData.
  - If w_writeReg=0, the write is silently dropped.
- Read: w_readDataN = reg[w_readRegN] combinationally; 0 when the index is 0.
- Read/write same index, same cycle: reads return the old value unless REGBANK_BYPASS_EN is defined (see Configuration).
- Indices 31 and 29 carry no special write behaviour. Any value produced by the destination mux is accepted. X or unknown mux selects are the mux's responsibility.
- No handshake. The control FSM holds flagRegWrite for exactly one cycle per writeback state. If it holds the flag for more cycles, the same value is rewritten each cycle, which is harmless.

## Timing
- Write latency: 1 cycle. Data written at edge N is visible on the read ports immediately after edge N.
- Read latency: 0 cycles (combinational from index to data).
- Reset: 1 edge. State is valid from the first edge where reset=0 is sampled. Deasserting reset does not itself write anything.
- Reset mid-operation: a write pending on the same edge is discarded; $29 returns to SP_INIT.
- Simultaneous write to index 0 and read of index 0: the read is 0, with or without bypass.

## Configuration
- REGBANK_BYPASS_EN defined: write-through forwarding.
  - If flagRegWrite=1, reset=1, w_writeReg!=0 and w_writeReg==w_readRegN, then w_readDataN = w_writeData in the same cycle.
  - Lets a future pipelined datapath avoid a writeback-to-decode hazard.
- Not defined: pure flop read. The old value is returned until the edge. The multicycle FSM never relies on bypass.

## Structure
- Shared package (cpu_pkg):
  - REG_ZERO=0, REG_SP=29, REG_RA=31
  - SP_INIT default
  - DATA_W and ADDR_W
  - the destination-select encodings consumed upstream: 000 rt, 001 rd, 010 $ra, 011 rs, 100 $sp
- One natural sub-module, reg_bank_rdport: a single read port, instantiated twice, containing the zero-index gating and the optional bypass compare.
- Storage and write logic stay in reg_bank.

## Test plan
- Reset=0 for 1 edge, then release → every read index returns 0 except 29, which returns 227; w_spOut=227.
- Write 32'hDEADBEEF to index 8 with flagRegWrite=1; next cycle read rs=8 → DEADBEEF. Read rt=9 → 0.
- Write 32'h12345678 to index 0 → reads of index 0 return 0 forever after.
- Destination mux select 010 (index 31) with w_writeData=32'h00400010 → reg31=00400010. Select 100 with 32'h000000E0 → w_spOut=E0.
- Same-cycle write 32'hA5A5A5A5 to index 5 while reading index 5 (reg5 previously 1):
  - without REGBANK_BYPASS_EN → reads 1 before the edge, A5A5A5A5 after;
  - with REGBANK_BYPASS_EN → reads A5A5A5A5 before the edge.
- Write of 32'hFFFFFFFF to index 29 on the same edge that reset=0 → $29=227, no other register changes from its reset value.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared definitions for the MIPS register file and the
// destination-register mux that sits upstream of it.
//   - register-file geometry (DATA_W, ADDR_W)
//   - architectural register indices ($zero, $sp, $ra)
//   - reset value of $sp
//   - destination-select encodings and a helper that resolves them
package reg_bank_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  localparam logic [31:0] SP_INIT_DEFAULT = 32'd227;

  // Destination-register mux selects driven by the control FSM.
  typedef enum logic [2:0] {
    DST_RT = 3'b000,
    DST_RD = 3'b001,
    DST_RA = 3'b010,
    DST_RS = 3'b011,
    DST_SP = 3'b100
  } dst_sel_e;

  // Resolves a destination select to a register index the way the
  // upstream mux does.
  function automatic logic [ADDR_W-1:0] dst_idx(input dst_sel_e sel,
                                                input logic [ADDR_W-1:0] rt,
                                                input logic [ADDR_W-1:0] rd,
                                                input logic [ADDR_W-1:0] rs);
    logic [ADDR_W-1:0] idx;
    idx = rt;
    case (sel)
      DST_RT: idx = rt;
      DST_RD: idx = rd;
      DST_RA: idx = ADDR_W'(REG_RA);
      DST_RS: idx = rs;
      DST_SP: idx = ADDR_W'(REG_SP);
      default: idx = rt;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/reg_bank_if.sv
// reg_bank_if: register-file access bundle between the datapath and reg_bank.
//   flagRegWrite  write enable from the control FSM
//   w_readReg1/2  rs/rt read indices
//   w_writeReg    write index (destination-mux output)
//   w_writeData   write data (memtoReg mux output)
//   w_readData1/2 rs/rt contents
//   w_spOut       current $sp
// master: datapath side; slave: register file side.
interface reg_bank_if #(
  parameter int DATA_W = reg_bank_pkg::DATA_W,
  parameter int ADDR_W = reg_bank_pkg::ADDR_W
);

  logic              flagRegWrite;
  logic [ADDR_W-1:0] w_readReg1;
  logic [ADDR_W-1:0] w_readReg2;
  logic [ADDR_W-1:0] w_writeReg;
  logic [DATA_W-1:0] w_writeData;
  logic [DATA_W-1:0] w_readData1;
  logic [DATA_W-1:0] w_readData2;
  logic [DATA_W-1:0] w_spOut;

  modport master (
    output flagRegWrite, w_readReg1, w_readReg2, w_writeReg, w_writeData,
    input  w_readData1, w_readData2, w_spOut
  );

  modport slave (
    input  flagRegWrite, w_readReg1, w_readReg2, w_writeReg, w_writeData,
    output w_readData1, w_readData2, w_spOut
  );

endinterface

// File: rtl/reg_bank_rdport.sv
// reg_bank_rdport: one combinational read port of the register file.
// Index 0 and the reset window read as 0. With REGBANK_BYPASS_EN defined,
// a same-cycle write to the read index is forwarded to the output.
// Ports:
//   active   reset deasserted (reads are forced to 0 otherwise)
//   idx      read index
//   reg_val  stored contents of register idx
//   wr_en, wr_idx, wr_data  write port (REGBANK_BYPASS_EN builds only)
//   data     read result
module reg_bank_rdport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              active,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] reg_val,
`ifdef REGBANK_BYPASS_EN
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [DATA_W-1:0] wr_data,
`endif
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = '0;
    if (active && (idx != '0)) begin
      data = reg_val;
`ifdef REGBANK_BYPASS_EN
      // idx is already known non-zero, so a dropped write to $zero never forwards.
      if (wr_en && (wr_idx == idx)) data = wr_data;
`endif
    end
  end

endmodule

// File: rtl/reg_bank.sv
// reg_bank: 32-entry general-purpose register file of the multicycle MIPS
// datapath. Two combinational read ports (rs, rt), one synchronous write
// port, synchronous active-low reset that clears everything except $sp,
// which loads SP_INIT.
// Optional build macro: REGBANK_BYPASS_EN (write-through forwarding on reads).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low
//   bus    reg_bank_if.slave (write port, read indices/data, $sp debug output)
module reg_bank #(
  parameter int                 DATA_W  = reg_bank_pkg::DATA_W,
  parameter int                 ADDR_W  = reg_bank_pkg::ADDR_W,
  parameter logic [DATA_W-1:0]  SP_INIT = DATA_W'(reg_bank_pkg::SP_INIT_DEFAULT),
  parameter int                 RA_IDX  = reg_bank_pkg::REG_RA,
  parameter int                 SP_IDX  = reg_bank_pkg::REG_SP
) (
  input logic       clk,
  input logic       reset,
  reg_bank_if.slave bus
);

  import reg_bank_pkg::*;

  localparam int NUM_REGS = 1 << ADDR_W;

  // $ra needs no special handling here (jal reaches it through the mux), but
  // both special indices must exist and $sp must not alias $zero.
  if ((SP_IDX >= NUM_REGS) || (SP_IDX == REG_ZERO) || (RA_IDX >= NUM_REGS)) begin : g_bad_idx
    $error("reg_bank: SP_IDX/RA_IDX out of range for ADDR_W");
  end

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Reset wins over a write on the same edge; writes to $zero are dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
    end else if (bus.flagRegWrite && (bus.w_writeReg != '0)) begin
      regs[bus.w_writeReg] <= bus.w_writeData;
    end
  end

  assign bus.w_spOut = regs[SP_IDX];

  reg_bank_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_rs (
    .active  (reset),
    .idx     (bus.w_readReg1),
    .reg_val (regs[bus.w_readReg1]),
`ifdef REGBANK_BYPASS_EN
    .wr_en   (bus.flagRegWrite),
    .wr_idx  (bus.w_writeReg),
    .wr_data (bus.w_writeData),
`endif
    .data    (bus.w_readData1)
  );

  reg_bank_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_rt (
    .active  (reset),
    .idx     (bus.w_readReg2),
    .reg_val (regs[bus.w_readReg2]),
`ifdef REGBANK_BYPASS_EN
    .wr_en   (bus.flagRegWrite),
    .wr_idx  (bus.w_writeReg),
    .wr_data (bus.w_writeData),
`endif
    .data    (bus.w_readData2)
  );

endmodule

// File: tb/tb_reg_bank.sv
module tb_reg_bank;
  import reg_bank_pkg::*;

  logic clk;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;

  reg_bank_if bus ();

  reg_bank dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One-cycle write pulse; returns 1 time unit after the write edge.
  task automatic wr(input logic [4:0] idx, input logic [31:0] data);
    bus.flagRegWrite = 1'b1;
    bus.w_writeReg   = idx;
    bus.w_writeData  = data;
    @(posedge clk);
    #1;
    bus.flagRegWrite = 1'b0;
  endtask

  task automatic rd(input logic [4:0] rs, input logic [4:0] rt);
    bus.w_readReg1 = rs;
    bus.w_readReg2 = rt;
    #1;
  endtask

  // Every register at its reset value: 0, except $sp = 227.
  task automatic scan_reset_state(input string tag);
    logic [31:0] e1, e2;
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i));
      e1 = (i == 29) ? 32'd227 : 32'd0;
      e2 = ((31 - i) == 29) ? 32'd227 : 32'd0;
      check($sformatf("%s rs%0d", tag, i), bus.w_readData1, e1);
      check($sformatf("%s rt%0d", tag, 31 - i), bus.w_readData2, e2);
    end
    check({tag, " sp"}, bus.w_spOut, 32'd227);
  endtask

  initial begin
    logic [4:0] d;
    reset            = 1'b0;
    bus.flagRegWrite = 1'b0;
    bus.w_readReg1   = 5'd29;
    bus.w_readReg2   = 5'd8;
    bus.w_writeReg   = 5'd0;
    bus.w_writeData  = 32'd0;

    // Reset edge: reads gated to 0, $sp shows its reset value.
    @(posedge clk);
    #1;
    check("rst rd1 gated", bus.w_readData1, 32'd0);
    check("rst rd2 gated", bus.w_readData2, 32'd0);
    check("rst sp", bus.w_spOut, 32'd227);

    reset = 1'b1;
    scan_reset_state("post_rst");
    @(posedge clk);
    #1;
    check("release no write sp", bus.w_spOut, 32'd227);

    // Basic write and independent read ports.
    wr(5'd8, 32'hDEADBEEF);
    rd(5'd8, 5'd9);
    check("r8 after write", bus.w_readData1, 32'hDEADBEEF);
    check("r9 untouched", bus.w_readData2, 32'd0);
    rd(5'd9, 5'd8);
    check("rt r8", bus.w_readData2, 32'hDEADBEEF);

    // $zero ignores writes.
    wr(5'd0, 32'h12345678);
    rd(5'd0, 5'd0);
    check("r0 rs after write", bus.w_readData1, 32'd0);
    check("r0 rt after write", bus.w_readData2, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("r0 later", bus.w_readData1, 32'd0);

    // Destination-mux selects for jal ($ra) and $sp.
    d = dst_idx(DST_RA, 5'd3, 5'd4, 5'd6);
    wr(d, 32'h00400010);
    rd(5'd31, 5'd29);
    check("ra via sel 010", bus.w_readData1, 32'h00400010);
    check("sp still init", bus.w_readData2, 32'd227);
    d = dst_idx(DST_SP, 5'd3, 5'd4, 5'd6);
    wr(d, 32'h000000E0);
    check("sp out via sel 100", bus.w_spOut, 32'h000000E0);
    rd(5'd29, 5'd31);
    check("rs r29", bus.w_readData1, 32'h000000E0);
    d = dst_idx(DST_RD, 5'd3, 5'd4, 5'd6);
    wr(d, 32'h00000044);
    rd(5'd4, 5'd3);
    check("rd sel 001", bus.w_readData1, 32'h00000044);
    check("rt r3 untouched", bus.w_readData2, 32'd0);

    // Same-cycle write and read of index 5.
    wr(5'd5, 32'd1);
    bus.flagRegWrite = 1'b1;
    bus.w_writeReg   = 5'd5;
    bus.w_writeData  = 32'hA5A5A5A5;
    rd(5'd5, 5'd4);
`ifdef REGBANK_BYPASS_EN
    check("r5 before edge", bus.w_readData1, 32'hA5A5A5A5);
`else
    check("r5 before edge", bus.w_readData1, 32'd1);
`endif
    check("r4 no bypass", bus.w_readData2, 32'h00000044);
    @(posedge clk);
    #1;
    bus.flagRegWrite = 1'b0;
    check("r5 after edge", bus.w_readData1, 32'hA5A5A5A5);

    // Same-cycle write to and read of $zero: always 0.
    bus.flagRegWrite = 1'b1;
    bus.w_writeReg   = 5'd0;
    bus.w_writeData  = 32'hCAFEF00D;
    rd(5'd0, 5'd0);
    check("r0 same cycle", bus.w_readData1, 32'd0);
    @(posedge clk);
    #1;
    bus.flagRegWrite = 1'b0;
    check("r0 after same cycle", bus.w_readData2, 32'd0);

    // Reset wins over a write to $sp on the same edge.
    reset            = 1'b0;
    bus.flagRegWrite = 1'b1;
    bus.w_writeReg   = 5'd29;
    bus.w_writeData  = 32'hFFFFFFFF;
    rd(5'd8, 5'd29);
    @(posedge clk);
    #1;
    check("rst+wr sp", bus.w_spOut, 32'd227);
    check("rst+wr rd1 gated", bus.w_readData1, 32'd0);
    check("rst+wr rd2 gated", bus.w_readData2, 32'd0);
    bus.flagRegWrite = 1'b0;
    reset = 1'b1;
    scan_reset_state("rst_mid");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
